// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for a pipelined MIPS-style CPU. It sits
// beside the decode (RF) stage and shadows every in-flight instruction in
// the STAGES stages after decode (stage 1 = EX ... stage STAGES = WB). It
// raises load-use stalls, turns the EX slot into a bubble on stall or flush,
// and hands registered forwarding selects to EX.
//
// Build option:
//   PIPE_HAZARD_FWD_EN  defined   -> forwarding enabled; only a load that has
//                                    not yet reached stage LOAD_LAT stalls.
//                       undefined -> no forwarding; ex_fwd_a/ex_fwd_b are 0
//                                    and any in-flight producer of a source
//                                    stalls decode until it has retired.
//
// Parameters:
//   REG_AW   register address width
//   STAGES   number of tracked post-decode stages
//   LOAD_LAT load result is forwardable from stage >= LOAD_LAT (1..STAGES)
//   FWD_W    forwarding select width (STAGES < 2**FWD_W)
//   CNT_W    stall counter width
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   id_valid             decode slot holds a real instruction
//   id_rs, id_rt         source registers
//   id_rs_used/rt_used   source is actually read
//   id_regwr, id_dst     instruction writes register id_dst
//   id_is_load           instruction is a load
//   flush                squash the decode slot
//   stall                hold PC and IF/RF this cycle (combinational)
//   ex_bubble            EX holds a bubble (registered)
//   ex_fwd_a, ex_fwd_b   forwarding selects for EX operands (registered);
//                        value k = producer in stage k+1 during EX, 0 = RF
//   stall_count          saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_regwr,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              ex_bubble,
  output logic [FWD_W-1:0]  ex_fwd_a,
  output logic [FWD_W-1:0]  ex_fwd_b,
  output logic [CNT_W-1:0]  stall_count
);

  // Tracking array, index 0 holds stage 1 (EX).
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] wr_q,  wr_d;
  logic [STAGES-1:0] ld_q,  ld_d;
  logic [REG_AW-1:0] dst_q [STAGES];
  logic [REG_AW-1:0] dst_d [STAGES];

  logic              ex_bubble_q, ex_bubble_d;
  logic [FWD_W-1:0]  fwd_a_q, fwd_a_d;
  logic [FWD_W-1:0]  fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [FWD_W-1:0]  win_a, win_b;
  logic              ldhz_a, ldhz_b;
  logic              hazard;
  logic              stall_int;
  logic              accept;

  // Decode-stage hazard detection
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    ldhz_a = 1'b0;
    ldhz_b = 1'b0;
    // Scan oldest to youngest so the youngest matching producer wins.
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (id_rs_used && (id_rs != '0) && vld_q[k] && wr_q[k] && (dst_q[k] == id_rs)) begin
        win_a  = FWD_W'(k + 1);
        ldhz_a = ld_q[k] && ((k + 1) < LOAD_LAT);
      end
      if (id_rt_used && (id_rt != '0) && vld_q[k] && wr_q[k] && (dst_q[k] == id_rt)) begin
        win_b  = FWD_W'(k + 1);
        ldhz_b = ld_q[k] && ((k + 1) < LOAD_LAT);
      end
    end
`ifdef PIPE_HAZARD_FWD_EN
    hazard = ldhz_a | ldhz_b;
`else
    // Without forwarding every producer blocks; a load-use hit is just a
    // special case of a producer hit.
    hazard = ldhz_a | ldhz_b | (win_a != '0) | (win_b != '0);
`endif
    // Flush squashes the slot, so it never needs to wait.
    stall_int = id_valid & ~flush & hazard;
    accept    = id_valid & ~flush & ~stall_int;
  end

  // Next state for the tracking array and EX-side registers
  always_comb begin
    vld_d    = '0;
    wr_d     = '0;
    ld_d     = '0;
    vld_d[0] = accept;
    wr_d[0]  = id_regwr;
    ld_d[0]  = id_is_load;
    dst_d[0] = id_dst;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      wr_d[k]  = wr_q[k-1];
      ld_d[k]  = ld_q[k-1];
      dst_d[k] = dst_q[k-1];
    end

    ex_bubble_d = ~accept;
`ifdef PIPE_HAZARD_FWD_EN
    fwd_a_d = accept ? win_a : '0;
    fwd_b_d = accept ? win_b : '0;
`else
    fwd_a_d = '0;
    fwd_b_d = '0;
`endif

    cnt_d = cnt_q;
    if (stall_int && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stage boundary: decode -> stage 1, stage k -> stage k+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      ex_bubble_q <= 1'b1;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      cnt_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      ex_bubble_q <= ex_bubble_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q  <= wr_d;
    ld_q  <= ld_d;
    dst_q <= dst_d;
  end

  assign stall       = stall_int;
  assign ex_bubble   = ex_bubble_q;
  assign ex_fwd_a    = fwd_a_q;
  assign ex_fwd_b    = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = 3;
`endif
  localparam int SAT_MAX = 7;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_regwr, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        stall, ex_bubble;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_count;

  logic        stall_s, ex_bubble_s;
  logic [1:0]  ex_fwd_a_s, ex_fwd_b_s;
  logic [2:0]  stall_count_s;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwr(id_regwr),
    .id_dst(id_dst), .id_is_load(id_is_load), .flush(flush), .stall(stall),
    .ex_bubble(ex_bubble), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_count(stall_count)
  );

  // Narrow counter instance for the saturation corner.
  pipe_hazard_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwr(id_regwr),
    .id_dst(id_dst), .id_is_load(id_is_load), .flush(flush), .stall(stall_s),
    .ex_bubble(ex_bubble_s), .ex_fwd_a(ex_fwd_a_s), .ex_fwd_b(ex_fwd_b_s),
    .stall_count(stall_count_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       vld;
    logic [4:0] rs;
    bit       rsu;
    logic [4:0] rt;
    bit       rtu;
    bit       wr;
    logic [4:0] dst;
    bit       ld;
    bit       fl;
    bit       st;
    bit       bub;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  vec_t tbl[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_cnt = 0;

  function automatic void add(input bit r, input bit vld, input int rs, input bit rsu,
                              input int rt, input bit rtu, input bit wr, input int dst,
                              input bit ld, input bit fl, input bit st, input bit bub,
                              input int fa, input int fb);
    vec_t v;
    v.rst = r;   v.vld = vld; v.rs = 5'(rs); v.rsu = rsu; v.rt = 5'(rt); v.rtu = rtu;
    v.wr = wr;   v.dst = 5'(dst); v.ld = ld; v.fl = fl;
    v.st = st;   v.bub = bub; v.fa = 2'(fa); v.fb = 2'(fb);
    tbl.push_back(v);
  endfunction

  function automatic int smin(input int a);
    return (a > SAT_MAX) ? SAT_MAX : a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs = v.rs; id_rs_used = v.rsu; id_rt = v.rt; id_rt_used = v.rtu;
    id_regwr = v.wr;  id_dst = v.dst; id_is_load = v.ld; flush = v.fl;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_regwr = 0; id_dst = 0; id_is_load = 0; flush = 0;
  endtask

  // LW $5,0($0) and ADD $6,$5,$5
  task automatic drive_lw();
    drive_idle(); id_valid = 1; id_rs_used = 1; id_rt = 5; id_regwr = 1; id_dst = 5; id_is_load = 1;
  endtask
  task automatic drive_add_dep();
    drive_idle(); id_valid = 1; id_rs = 5; id_rs_used = 1; id_rt = 5; id_rt_used = 1;
    id_regwr = 1; id_dst = 6;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " stall"},      32'(stall), 0);
    check({tag, " ex_bubble"},  32'(ex_bubble), 1);
    check({tag, " ex_fwd_a"},   32'(ex_fwd_a), 0);
    check({tag, " ex_fwd_b"},   32'(ex_fwd_b), 0);
    check({tag, " count"},      32'(stall_count), 0);
    check({tag, " count_sat"},  32'(stall_count_s), 0);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    drive(v);
    #3;
    check($sformatf("v%0d stall", i),     32'(stall),   32'(v.st));
    check($sformatf("v%0d stall_sat", i), 32'(stall_s), 32'(v.st));
    @(posedge clk);
    #1;
    if (v.st) exp_cnt++;
    check($sformatf("v%0d ex_bubble", i), 32'(ex_bubble), 32'(v.bub));
    check($sformatf("v%0d ex_fwd_a", i),  32'(ex_fwd_a),  32'(v.fa));
    check($sformatf("v%0d ex_fwd_b", i),  32'(ex_fwd_b),  32'(v.fb));
    check($sformatf("v%0d count", i),     32'(stall_count),   32'(exp_cnt));
    check($sformatf("v%0d count_sat", i), 32'(stall_count_s), 32'(smin(exp_cnt)));
  endtask

  initial begin
    clk   = 0;
    rst_n = 1;
    drive_idle();

    //   r  v  rs u  rt u  wr dst ld fl   st bub fa fb
`ifdef PIPE_HAZARD_FWD_EN
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3,$1,$2
    add(0, 1, 3, 1, 1, 1, 1, 4, 0, 0,  0, 0, 1, 0);  // SUB $4,$3,$1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  1, 1, 0, 0);  // ADD $6,$5,$5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  0, 0, 2, 2);
    add(1, 1, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);  // ADDI $0,$0,7
    add(0, 1, 0, 1, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0);  // ADD $1,$0,$0
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 1,  0, 1, 0, 0);  // dependent ADD, flushed
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3
    add(0, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3 again
    add(0, 1, 3, 1, 3, 1, 1, 4, 0, 0,  0, 0, 1, 1);  // youngest wins
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 1, 3, 1, 3, 0, 1, 4, 0, 0,  0, 0, 3, 0);  // producer in WB, rt unused
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 1, 5, 1, 0, 1, 1, 6, 0, 0,  0, 0, 2, 0);  // ADD $6,$5,$0
`else
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3,$1,$2
    add(0, 1, 3, 1, 1, 1, 1, 4, 0, 0,  1, 1, 0, 0);  // SUB $4,$3,$1
    add(0, 1, 3, 1, 1, 1, 1, 4, 0, 0,  1, 1, 0, 0);
    add(0, 1, 3, 1, 1, 1, 1, 4, 0, 0,  1, 1, 0, 0);
    add(0, 1, 3, 1, 1, 1, 1, 4, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  1, 1, 0, 0);  // ADD $6,$5,$5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  1, 1, 0, 0);
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  1, 1, 0, 0);
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);  // ADDI $0,$0,7
    add(0, 1, 0, 1, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0);  // ADD $1,$0,$0
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 1, 5, 1, 5, 1, 1, 6, 0, 1,  0, 1, 0, 0);  // dependent ADD, flushed
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3
    add(0, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3 again
    add(0, 1, 3, 1, 3, 1, 1, 4, 0, 0,  1, 1, 0, 0);  // waits for the younger one
    add(0, 1, 3, 1, 3, 1, 1, 4, 0, 0,  1, 1, 0, 0);
    add(0, 1, 3, 1, 3, 1, 1, 4, 0, 0,  1, 1, 0, 0);
    add(0, 1, 3, 1, 3, 1, 1, 4, 0, 0,  0, 0, 0, 0);
    add(1, 1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0);  // ADD $3
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 1, 3, 1, 3, 0, 1, 4, 0, 0,  1, 1, 0, 0);  // producer in WB, rt unused
    add(0, 1, 3, 1, 3, 0, 1, 4, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0);  // LW $5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 1, 5, 1, 0, 1, 1, 6, 0, 0,  1, 1, 0, 0);  // ADD $6,$5,$0
    add(0, 1, 5, 1, 0, 1, 1, 6, 0, 0,  1, 1, 0, 0);
    add(0, 1, 5, 1, 0, 1, 1, 6, 0, 0,  0, 0, 0, 0);
`endif

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      run_vec(i);
    end

    // Repeated load-use pairs drive the narrow counter into saturation.
    do_reset();
    for (int it = 1; it <= 10; it++) begin
      int  n;
      bit  s;
      drive_lw();
      @(posedge clk);
      #1;
      drive_add_dep();
      n = 0;
      for (int c = 0; c < 8; c++) begin
        #3;
        s = stall;
        @(posedge clk);
        #1;
        if (s) n++;
        else break;
      end
      check($sformatf("pair%0d stall_cycles", it), 32'(n), 32'(LU_STALLS));
      exp_cnt += LU_STALLS;
      check($sformatf("pair%0d count", it),     32'(stall_count),   32'(exp_cnt));
      check($sformatf("pair%0d count_sat", it), 32'(stall_count_s), 32'(smin(exp_cnt)));
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a load-use stall.
    drive_lw();
    @(posedge clk);
    #1;
    drive_add_dep();
    #3;
    check("midrst stall_before", 32'(stall), 1);
    rst_n = 0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1;
    #1;
    check("midrst stall_after_release", 32'(stall), 0);
    @(posedge clk);
    #1;
    exp_cnt = 0;
    check("midrst first_edge_bubble", 32'(ex_bubble), 0);
    check("midrst first_edge_fwd_a",  32'(ex_fwd_a), 0);
    check("midrst first_edge_fwd_b",  32'(ex_fwd_b), 0);
    check("midrst first_edge_count",  32'(stall_count), 32'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
